pcie2_x1_ctc_seq: RTL and testbench

- Rec_clk-domain sequencer for the x1 clock-tolerance-compensation (CTC) elastic FIFO.
- Drives the FIFO's ctc_dsb and ctc_pause controls from lane-sync, ordered-set and overflow status.
- CTC is enabled only after stable lane sync and aligned SKP traffic; after an overflow it pauses and re-hunts.
- Sits between the lane-sync/word-align stage and the CTC FIFO, on the same rec_clk data bus the FIFO consumes.

---
 rtl/pcie2_x1_ctc_pkg.sv | 31 +++
 rtl/pcie2_x1_ctc_skp_det.sv | 40 ++++
 rtl/pcie2_x1_ctc_seq.sv | 183 ++++++++++++++++++
 tb/tb_pcie2_x1_ctc_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie2_x1_ctc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pcie2_x1_ctc_pkg
// Brief   : Shared types, K-codes and counter sizing for the x1 CTC sequencer.
// Revision: 1.0
// ============================================================================
package pcie2_x1_ctc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOCK    = 3'd1,
        ST_HUNT    = 3'd2,
        ST_RUN     = 3'd3,
        ST_RECOVER = 3'd4
    } ctc_state_e;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;

    localparam int unsigned LOCK_CYCLES_DEF  = 64;
    localparam int unsigned SKP_HUNT_N_DEF   = 2;
    localparam int unsigned PAUSE_CYCLES_DEF = 16;
    localparam int unsigned SKP_TIMEOUT_DEF  = 4096;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie2_x1_ctc_skp_det.sv
`default_nettype none
// ============================================================================
// Module  : pcie2_x1_ctc_skp_det
// Brief   : Registered COM,SKP detector, aligned or straddling two words.
// Revision: 1.0
// ============================================================================
module pcie2_x1_ctc_skp_det
    import pcie2_x1_ctc_pkg::*;
(
    input  logic        rec_clk,
    input  logic        rst_n,
    input  logic        lsyn_in,
    input  logic [15:0] d_in,
    input  logic [1:0]  k_in,
    output logic        skp_hit
);

    logic com_hi_q, com_hi_d;
    logic hit_q, hit_d;

    always_comb begin
        com_hi_d = lsyn_in && k_in[1] && (d_in[15:8] == K_COM);
        hit_d    = ((k_in == 2'b11) && (d_in[7:0] == K_COM) && (d_in[15:8] == K_SKP))
                || (com_hi_q && k_in[0] && (d_in[7:0] == K_SKP));
    end

    always_ff @(posedge rec_clk or negedge rst_n) begin
        if (!rst_n) begin
            com_hi_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            com_hi_q <= com_hi_d;
            hit_q    <= hit_d;
        end
    end

    assign skp_hit = hit_q;

endmodule
`default_nettype wire

// File: rtl/pcie2_x1_ctc_seq.sv
`default_nettype none
// ============================================================================
// Module  : pcie2_x1_ctc_seq
// Brief   : Rec_clk CTC sequencer driving the elastic FIFO disable/pause.
//           Define CTC_SEQ_STATS_EN to enable overflow/recover statistics.
// Revision: 1.0
// ============================================================================
module pcie2_x1_ctc_seq
    import pcie2_x1_ctc_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES  = LOCK_CYCLES_DEF,
    parameter int unsigned SKP_HUNT_N   = SKP_HUNT_N_DEF,
    parameter int unsigned PAUSE_CYCLES = PAUSE_CYCLES_DEF,
    parameter int unsigned SKP_TIMEOUT  = SKP_TIMEOUT_DEF
) (
    input  logic        rst_n,
    input  logic        rec_clk,
    input  logic        lsyn_in,
    input  logic [15:0] d_in,
    input  logic [1:0]  k_in,
    input  logic        oflow_in,
    input  logic        force_dsb,
    output logic        ctc_dsb,
    output logic        ctc_pause,
    output logic        ctc_active,
    output logic        skp_tmo,
    output logic [2:0]  state_o,
    output logic [15:0] oflow_cnt,
    output logic [15:0] rec_cnt
);

    localparam int unsigned LOCK_W  = cnt_w(LOCK_CYCLES);
    localparam int unsigned HUNT_W  = cnt_w(SKP_HUNT_N);
    localparam int unsigned PAUSE_W = cnt_w(PAUSE_CYCLES);
    localparam int unsigned TMO_W   = cnt_w(SKP_TIMEOUT);

    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [HUNT_W-1:0]  HUNT_LAST  = HUNT_W'(SKP_HUNT_N - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(SKP_TIMEOUT - 1);

    ctc_state_e         state_q, state_d;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [HUNT_W-1:0]  skp_cnt_q, skp_cnt_d;
    logic [PAUSE_W-1:0] pause_cnt_q, pause_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               oflow_q;
    logic               oflow_edge;
    logic               tmo_fire;
    logic               skp_hit;

    pcie2_x1_ctc_skp_det u_skp_det (
        .rec_clk (rec_clk),
        .rst_n   (rst_n),
        .lsyn_in (lsyn_in),
        .d_in    (d_in),
        .k_in    (k_in),
        .skp_hit (skp_hit)
    );

    assign oflow_edge = oflow_in && !oflow_q;

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        skp_cnt_d   = skp_cnt_q;
        pause_cnt_d = pause_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_fire    = 1'b0;
        if (force_dsb || ((state_q != ST_IDLE) && !lsyn_in)) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                // The IDLE sample with lsyn_in high counts as the first locked cycle.
                ST_IDLE: begin
                    if (lsyn_in) begin
                        state_d    = ST_LOCK;
                        lock_cnt_d = LOCK_W'(1);
                    end
                end
                ST_LOCK: begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_d   = ST_HUNT;
                        skp_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                    end
                end
                ST_HUNT: begin
                    if (skp_hit) begin
                        if (skp_cnt_q == HUNT_LAST) begin
                            state_d   = ST_RUN;
                            tmo_cnt_d = '0;
                        end else begin
                            skp_cnt_d = skp_cnt_q + HUNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (oflow_edge) begin
                        state_d     = ST_RECOVER;
                        pause_cnt_d = '0;
                    end else if (skp_hit) begin
                        tmo_cnt_d = '0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_fire  = 1'b1;
                        tmo_cnt_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
                ST_RECOVER: begin
                    if (oflow_edge) begin
                        pause_cnt_d = '0;
                    end else if (pause_cnt_q == PAUSE_LAST) begin
                        state_d   = ST_HUNT;
                        skp_cnt_d = '0;
                    end else begin
                        pause_cnt_d = pause_cnt_q + PAUSE_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_ff @(posedge rec_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lock_cnt_q  <= '0;
            skp_cnt_q   <= '0;
            pause_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            oflow_q     <= 1'b0;
            ctc_dsb     <= 1'b1;
            ctc_pause   <= 1'b0;
            ctc_active  <= 1'b0;
            skp_tmo     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            skp_cnt_q   <= skp_cnt_d;
            pause_cnt_q <= pause_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            oflow_q     <= oflow_in;
            ctc_dsb     <= (state_d == ST_IDLE) || (state_d == ST_LOCK) || (state_d == ST_HUNT);
            ctc_pause   <= (state_d == ST_RECOVER);
            ctc_active  <= (state_d == ST_RUN);
            skp_tmo     <= tmo_fire;
        end
    end

    assign state_o = state_q;

`ifdef CTC_SEQ_STATS_EN
    logic [15:0] oflow_cnt_q;
    logic [15:0] rec_cnt_q;

    always_ff @(posedge rec_clk or negedge rst_n) begin
        if (!rst_n) begin
            oflow_cnt_q <= '0;
            rec_cnt_q   <= '0;
        end else begin
            if (oflow_edge && (oflow_cnt_q != 16'hFFFF)) begin
                oflow_cnt_q <= oflow_cnt_q + 16'd1;
            end
            if ((state_q == ST_RUN) && (state_d == ST_RECOVER) && (rec_cnt_q != 16'hFFFF)) begin
                rec_cnt_q <= rec_cnt_q + 16'd1;
            end
        end
    end

    assign oflow_cnt = oflow_cnt_q;
    assign rec_cnt   = rec_cnt_q;
`else
    assign oflow_cnt = 16'h0000;
    assign rec_cnt   = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie2_x1_ctc_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_pcie2_x1_ctc_seq
// Brief   : Directed and randomized bench for pcie2_x1_ctc_seq with a
//           cycle-level behavioural model of the sequencing rules.
// Revision: 1.0
// ============================================================================
module tb_pcie2_x1_ctc_seq;

    localparam int LOCK_C  = 64;
    localparam int HUNT_N  = 2;
    localparam int PAUSE_C = 16;
    localparam int TMO_C   = 4096;

    localparam int M_IDLE = 0, M_LOCK = 1, M_HUNT = 2, M_RUN = 3, M_REC = 4;

    logic        rec_clk   = 1'b0;
    logic        rst_n     = 1'b0;
    logic        lsyn_in   = 1'b0;
    logic [15:0] d_in      = 16'h0000;
    logic [1:0]  k_in      = 2'b00;
    logic        oflow_in  = 1'b0;
    logic        force_dsb = 1'b0;
    logic        ctc_dsb, ctc_pause, ctc_active, skp_tmo;
    logic [2:0]  state_o;
    logic [15:0] oflow_cnt, rec_cnt;

    pcie2_x1_ctc_seq #(
        .LOCK_CYCLES  (LOCK_C),
        .SKP_HUNT_N   (HUNT_N),
        .PAUSE_CYCLES (PAUSE_C),
        .SKP_TIMEOUT  (TMO_C)
    ) dut (
        .rst_n      (rst_n),
        .rec_clk    (rec_clk),
        .lsyn_in    (lsyn_in),
        .d_in       (d_in),
        .k_in       (k_in),
        .oflow_in   (oflow_in),
        .force_dsb  (force_dsb),
        .ctc_dsb    (ctc_dsb),
        .ctc_pause  (ctc_pause),
        .ctc_active (ctc_active),
        .skp_tmo    (skp_tmo),
        .state_o    (state_o),
        .oflow_cnt  (oflow_cnt),
        .rec_cnt    (rec_cnt)
    );

    always #5 rec_clk = ~rec_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int m_mode, m_run_len, m_hits, m_quiet, m_left;
    bit m_hit, m_prev_com, m_oprev;
    bit e_dsb, e_pause, e_active, e_tmo;
    int e_ocnt, e_rcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_run_len = 0; m_hits = 0; m_quiet = 0; m_left = 0;
        m_hit = 1'b0; m_prev_com = 1'b0; m_oprev = 1'b0;
        e_dsb = 1'b1; e_pause = 1'b0; e_active = 1'b0; e_tmo = 1'b0;
        e_ocnt = 0; e_rcnt = 0;
    endtask

    task automatic model_edge();
        bit ofl_edge;
        bit hit;
        int nm;
        ofl_edge = oflow_in && !m_oprev;
        hit      = m_hit;
        nm       = m_mode;
        e_tmo    = 1'b0;
        if (ofl_edge && e_ocnt < 65535) e_ocnt++;
        if (force_dsb || (m_mode != M_IDLE && !lsyn_in)) begin
            nm = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (lsyn_in) begin nm = M_LOCK; m_run_len = 1; end
                M_LOCK: begin
                    m_run_len++;
                    if (m_run_len >= LOCK_C) begin nm = M_HUNT; m_hits = 0; end
                end
                M_HUNT: if (hit) begin
                    m_hits++;
                    if (m_hits >= HUNT_N) begin nm = M_RUN; m_quiet = 0; end
                end
                M_RUN: begin
                    if (ofl_edge) begin
                        nm = M_REC; m_left = PAUSE_C;
                        if (e_rcnt < 65535) e_rcnt++;
                    end else if (hit) begin
                        m_quiet = 0;
                    end else begin
                        m_quiet++;
                        if (m_quiet >= TMO_C) begin e_tmo = 1'b1; m_quiet = 0; end
                    end
                end
                M_REC: begin
                    if (ofl_edge) m_left = PAUSE_C;
                    else begin
                        m_left--;
                        if (m_left == 0) begin nm = M_HUNT; m_hits = 0; end
                    end
                end
                default: nm = M_IDLE;
            endcase
        end
        m_hit      = (k_in == 2'b11 && d_in == 16'h1CBC) || (m_prev_com && k_in[0] && d_in[7:0] == 8'h1C);
        m_prev_com = lsyn_in && k_in[1] && d_in[15:8] == 8'hBC;
        m_oprev    = oflow_in;
        m_mode     = nm;
        e_dsb      = (nm == M_IDLE || nm == M_LOCK || nm == M_HUNT);
        e_pause    = (nm == M_REC);
        e_active   = (nm == M_RUN);
    endtask

    task automatic check_all();
        chk("state", 32'(state_o), 32'(m_mode));
        chk("ctc_dsb", 32'(ctc_dsb), 32'(e_dsb));
        chk("ctc_pause", 32'(ctc_pause), 32'(e_pause));
        chk("ctc_active", 32'(ctc_active), 32'(e_active));
        chk("skp_tmo", 32'(skp_tmo), 32'(e_tmo));
`ifdef CTC_SEQ_STATS_EN
        chk("oflow_cnt", 32'(oflow_cnt), 32'(e_ocnt));
        chk("rec_cnt", 32'(rec_cnt), 32'(e_rcnt));
`else
        chk("oflow_cnt", 32'(oflow_cnt), 32'd0);
        chk("rec_cnt", 32'(rec_cnt), 32'd0);
`endif
    endtask

    task automatic cyc();
        @(posedge rec_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic filler();
        d_in = 16'($urandom);
        k_in = 2'b00;
    endtask

    task automatic aligned();
        d_in = 16'h1CBC;
        k_in = 2'b11;
    endtask

    function automatic logic [8:0] rnd_sym();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0, 1:    return {1'b1, 8'hBC};
            2, 3:    return {1'b1, 8'h1C};
            4:       return {1'b0, 8'hBC};
            5:       return {1'b0, 8'h1C};
            default: return 9'($urandom);
        endcase
    endfunction

    task automatic go_run();
        lsyn_in = 1'b1;
        filler();
        repeat (LOCK_C) cyc();
        chk("lock64_state", 32'(state_o), 32'd2);
        aligned();
        cyc();
        cyc();
        chk("hunt_dsb_hold", 32'(ctc_dsb), 32'd1);
        filler();
        cyc();
        chk("run_dsb", 32'(ctc_dsb), 32'd0);
        chk("run_active", 32'(ctc_active), 32'd1);
        chk("run_state", 32'(state_o), 32'd3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "time limit");
    end

    initial begin
        logic [8:0] s0, s1;
        int n;
        model_reset();
        #12;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_dsb", 32'(ctc_dsb), 32'd1);
        chk("rst_pause", 32'(ctc_pause), 32'd0);
        chk("rst_active", 32'(ctc_active), 32'd0);
        chk("rst_tmo", 32'(skp_tmo), 32'd0);
        rst_n = 1'b1;

        // 63 locked cycles then a drop: never leaves the disabled states
        filler();
        lsyn_in = 1'b1;
        repeat (LOCK_C - 1) begin
            cyc();
            chk("lock63_dsb", 32'(ctc_dsb), 32'd1);
        end
        lsyn_in = 1'b0;
        cyc();
        chk("lock63_idle", 32'(state_o), 32'd0);

        go_run();

        // Timeout: pulse on the 4096th quiet cycle, state stays RUN
        repeat (TMO_C - 1) cyc();
        cyc();
        chk("tmo_pulse", 32'(skp_tmo), 32'd1);
        chk("tmo_state", 32'(state_o), 32'd3);
        repeat (TMO_C - 2) cyc();
        aligned();
        cyc();
        filler();
        cyc();
        chk("tmo_suppressed", 32'(skp_tmo), 32'd0);
        repeat (3) cyc();

        // Overflow -> 16 pause cycles -> HUNT
        oflow_in = 1'b1;
        cyc();
        oflow_in = 1'b0;
        chk("rec_pause", 32'(ctc_pause), 32'd1);
        chk("rec_state", 32'(state_o), 32'd4);
        chk("rec_dsb", 32'(ctc_dsb), 32'd0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (ctc_pause) n++;
            else break;
        end
        chk("pause_len", 32'(n), 32'd16);
        chk("post_rec_state", 32'(state_o), 32'd2);
        chk("post_rec_dsb", 32'(ctc_dsb), 32'd1);
`ifdef CTC_SEQ_STATS_EN
        chk("stat_oflow", 32'(oflow_cnt), 32'd1);
        chk("stat_rec", 32'(rec_cnt), 32'd1);
`endif

        // Straddled bytes without K flags must not count
        repeat (2) begin
            d_in = {8'hBC, 8'($urandom)}; k_in = 2'b00; cyc();
            d_in = {8'($urandom), 8'h1C}; k_in = 2'b00; cyc();
        end
        filler();
        repeat (3) cyc();
        chk("strad_nok_state", 32'(state_o), 32'd2);
        repeat (2) begin
            d_in = {8'hBC, 8'($urandom)}; k_in = 2'b10; cyc();
            d_in = {8'($urandom), 8'h1C}; k_in = 2'b01; cyc();
        end
        chk("strad_pre_state", 32'(state_o), 32'd2);
        filler();
        cyc();
        chk("strad_run_state", 32'(state_o), 32'd3);

        // force_dsb during RECOVER
        oflow_in = 1'b1;
        cyc();
        oflow_in = 1'b0;
        repeat (5) cyc();
        chk("force_pre_state", 32'(state_o), 32'd4);
        force_dsb = 1'b1;
        cyc();
        chk("force_dsb", 32'(ctc_dsb), 32'd1);
        chk("force_pause", 32'(ctc_pause), 32'd0);
        chk("force_state", 32'(state_o), 32'd0);
        force_dsb = 1'b0;

        // Asynchronous reset in the middle of RUN
        go_run();
        repeat (7) cyc();
        #2;
        rst_n   = 1'b0;
        lsyn_in = 1'b0;
        #1;
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_dsb", 32'(ctc_dsb), 32'd1);
        chk("arst_pause", 32'(ctc_pause), 32'd0);
        chk("arst_active", 32'(ctc_active), 32'd0);
        chk("arst_tmo", 32'(skp_tmo), 32'd0);
        chk("arst_ocnt", 32'(oflow_cnt), 32'd0);
        chk("arst_rcnt", 32'(rec_cnt), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            lsyn_in   = ($urandom_range(0, 199) != 0);
            force_dsb = ($urandom_range(0, 399) == 0);
            oflow_in  = ($urandom_range(0, 59) == 0);
            s0 = rnd_sym();
            s1 = rnd_sym();
            if ($urandom_range(0, 9) == 0) begin
                aligned();
            end else begin
                d_in = {s1[7:0], s0[7:0]};
                k_in = {s1[8], s0[8]};
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
